ub_loop_nest_controller: RTL and testbench

Schedule controller for a unified-buffer (`*_ub`) pair. It walks a 3-deep affine loop nest and drives the producer port's write enable and `write_ctrl_vars[2:0]`. It drives the consumer port's read enable and `read_ctrl_vars[2:0]` as the same iteration stream delayed by a fixed schedule offset. It sits between the top-level start/stall control and one buffer instance, replacing hand-wired counters per app.

---
 rtl/ub_ctrl_pkg.sv | 23 ++
 rtl/ub_ctrl_delay_line.sv | 45 ++++
 rtl/ub_loop_nest_controller.sv | 165 ++++++++++++++++
 tb/tb_ub_loop_nest_controller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ub_ctrl_pkg.sv
// Shared types and constants for the unified-buffer loop-nest controller.
package ub_ctrl_pkg;

  localparam int CTRL_W  = 16;  // width of each loop index
  localparam int NDIMS   = 3;   // depth of the loop nest
  localparam int DRAIN_W = 4;   // width of the drain (read-delay) counter

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  // One loop index per dimension; element [i] is the 16-bit ctrl_vars[i].
  typedef logic [NDIMS-1:0][CTRL_W-1:0] ctrl_vec_t;

  // One slot of the read-side shift line: an iteration and whether it was issued.
  typedef struct packed {
    logic      valid;
    ctrl_vec_t vars;
  } line_entry_t;

endpackage

// File: rtl/ub_ctrl_delay_line.sv
// Fixed-depth shift line that replays the write iteration stream on the read side.
// A depth of zero collapses to a combinational passthrough.
module ub_ctrl_delay_line
  import ub_ctrl_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en_i,
  input  logic      clr_i,
  input  logic      valid_i,
  input  ctrl_vec_t vars_i,
  output logic      valid_o,
  output ctrl_vec_t vars_o
);

  if (DEPTH == 0) begin : g_passthru
    // Sequencing inputs have no function without storage.
    logic unused_seq;
    assign unused_seq = ^{clk, rst_n, en_i, clr_i};
    assign valid_o    = valid_i;
    assign vars_o     = vars_i;
  end else begin : g_line
    line_entry_t line_q [DEPTH];

    // Shift one slot per unstalled cycle; flush empties the whole line.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: the line is reset like any other register because its last
        // slot drives output ports that must read 0 straight out of reset.
        for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
      end else if (clr_i) begin
        for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
      end else if (en_i) begin
        line_q[0] <= '{valid: valid_i, vars: vars_i};
        for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
      end
    end

    assign valid_o = line_q[DEPTH-1].valid;
    assign vars_o  = line_q[DEPTH-1].vars;
  end

endmodule

// File: rtl/ub_loop_nest_controller.sv
// Schedule controller for a unified-buffer pair: walks a 3-deep loop nest,
// issues producer writes and replays them READ_DELAY cycles later as reads.
module ub_loop_nest_controller
  import ub_ctrl_pkg::*;
#(
  parameter int EXT0       = 1,
  parameter int EXT2       = 64,
  parameter int EXT1       = 64,
  parameter int READ_DELAY = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      start,
  input  logic      stall,
  output logic      write_wen,
  output ctrl_vec_t write_ctrl_vars,
  output logic      read_ren,
  output ctrl_vec_t read_ctrl_vars,
  output logic      busy,
  output logic      done
);

  localparam logic [CTRL_W-1:0]  MAX0       = CTRL_W'(EXT0 - 1);
  localparam logic [CTRL_W-1:0]  MAX1       = CTRL_W'(EXT1 - 1);
  localparam logic [CTRL_W-1:0]  MAX2       = CTRL_W'(EXT2 - 1);
  localparam logic [CTRL_W-1:0]  ONE        = CTRL_W'(1);
  localparam ctrl_vec_t          LAST_VEC   = {MAX2, MAX1, MAX0};
  localparam logic [DRAIN_W-1:0] DRAIN_LAST =
    DRAIN_W'((READ_DELAY == 0) ? 0 : READ_DELAY - 1);

  state_e              state_q, state_d;
  ctrl_vec_t           cnt_q, cnt_d, cnt_adv;
  logic                wen_q, wen_d;
  ctrl_vec_t           wvars_q, wvars_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                last_issued;
  logic                line_valid;
  ctrl_vec_t           line_vars;

  // Iteration after cnt_q: innermost [1] wraps into middle [2], which wraps into outer [0].
  always_comb begin
    cnt_adv = cnt_q;
    if (cnt_q[1] == MAX1) begin
      cnt_adv[1] = '0;
      if (cnt_q[2] == MAX2) begin
        cnt_adv[2] = '0;
        cnt_adv[0] = (cnt_q[0] == MAX0) ? '0 : cnt_q[0] + ONE;
      end else begin
        cnt_adv[2] = cnt_q[2] + ONE;
      end
    end else begin
      cnt_adv[1] = cnt_q[1] + ONE;
    end
  end

  // In RUN the write register always holds the most recently issued iteration.
  assign last_issued = (wvars_q == LAST_VEC);

  // Next-state and registered-output logic; flush beats stall and start.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    wvars_d = wvars_q;
    drain_d = drain_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      wen_d   = 1'b0;
      wvars_d = '0;
      drain_d = '0;
      busy_d  = 1'b0;
    end else if (!stall) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            wen_d   = 1'b1;
            wvars_d = cnt_q;
            cnt_d   = cnt_adv;
            busy_d  = 1'b1;
          end
        end
        RUN: begin
          if (last_issued) begin
            wen_d = 1'b0;
            if (READ_DELAY == 0) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = DRAIN;
              drain_d = '0;
            end
          end else begin
            wen_d   = 1'b1;
            wvars_d = cnt_q;
            cnt_d   = cnt_adv;
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            drain_d = drain_q + DRAIN_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs; reset returns everything to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      wvars_q <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples values from before the edge.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      wvars_q <= wvars_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  ub_ctrl_delay_line #(
    .DEPTH (READ_DELAY)
  ) u_delay_line (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (!stall),
    .clr_i   (flush),
    .valid_i (wen_q),
    .vars_i  (wvars_q),
    .valid_o (line_valid),
    .vars_o  (line_vars)
  );

  // A stalled cycle presents no transfer; the held slot completes once stall drops.
  assign write_wen       = wen_q & ~stall;
  assign write_ctrl_vars = wvars_q;
  assign read_ren        = line_valid & ~stall;
  assign read_ctrl_vars  = line_vars;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_ub_loop_nest_controller.sv
// Directed bench for ub_loop_nest_controller: three instances cover the
// reference 1x2x3 nest with delay 1, the same nest with delay 0, and a
// 2x2x2 nest with delay 2 that exercises the outermost carry.
module tb_ub_loop_nest_controller;
  import ub_ctrl_pkg::*;

  localparam ctrl_vec_t ZV = '0;

  logic clk, rst_n;
  int   checks = 0;
  int   errors = 0;

  logic a_flush, a_start, a_stall, a_wen, a_ren, a_busy, a_done;
  ctrl_vec_t a_wvars, a_rvars;
  logic z_flush, z_start, z_stall, z_wen, z_ren, z_busy, z_done;
  ctrl_vec_t z_wvars, z_rvars;
  logic c_flush, c_start, c_stall, c_wen, c_ren, c_busy, c_done;
  ctrl_vec_t c_wvars, c_rvars;

  ub_loop_nest_controller #(.EXT0(1), .EXT2(2), .EXT1(3), .READ_DELAY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .start(a_start), .stall(a_stall),
    .write_wen(a_wen), .write_ctrl_vars(a_wvars), .read_ren(a_ren),
    .read_ctrl_vars(a_rvars), .busy(a_busy), .done(a_done));

  ub_loop_nest_controller #(.EXT0(1), .EXT2(2), .EXT1(3), .READ_DELAY(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .flush(z_flush), .start(z_start), .stall(z_stall),
    .write_wen(z_wen), .write_ctrl_vars(z_wvars), .read_ren(z_ren),
    .read_ctrl_vars(z_rvars), .busy(z_busy), .done(z_done));

  ub_loop_nest_controller #(.EXT0(2), .EXT2(2), .EXT1(2), .READ_DELAY(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .start(c_start), .stall(c_stall),
    .write_wen(c_wen), .write_ctrl_vars(c_wvars), .read_ren(c_ren),
    .read_ctrl_vars(c_rvars), .busy(c_busy), .done(c_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected loop indices of iteration j: [1] innermost, [2] middle, [0] outermost.
  function automatic ctrl_vec_t iter_vec(input int j, input int e1, input int e2);
    ctrl_vec_t v;
    v[1] = 16'(j % e1);
    v[2] = 16'((j / e1) % e2);
    v[0] = 16'(j / (e1 * e2));
    return v;
  endfunction

  task automatic test_reset();
    logic seen;
    rst_n = 1'b0;
    a_start = 1'b1; z_start = 1'b1; c_start = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_wen, a_ren, a_busy, a_done, a_wvars, a_rvars} !== '0) begin
      errors++;
      $display("FAIL reset_a: got %h want 0", {a_wen, a_ren, a_busy, a_done, a_wvars, a_rvars});
    end
    checks++;
    if ({z_wen, z_ren, z_busy, z_done, z_wvars, z_rvars} !== '0) begin
      errors++;
      $display("FAIL reset_z: got %h want 0", {z_wen, z_ren, z_busy, z_done, z_wvars, z_rvars});
    end
    checks++;
    if ({c_wen, c_ren, c_busy, c_done, c_wvars, c_rvars} !== '0) begin
      errors++;
      $display("FAIL reset_c: got %h want 0", {c_wen, c_ren, c_busy, c_done, c_wvars, c_rvars});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_start = 1'b0; z_start = 1'b0; c_start = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | a_wen | a_ren | a_busy | a_done | z_wen | z_ren | z_busy | z_done
                  | c_wen | c_ren | c_busy | c_done;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got activity %b want 0", seen);
    end
  endtask

  task automatic test_full_pass();
    logic ew, er, ed, eb;
    logic [99:0] exp_v, obs_v;
    for (int k = 0; k <= 9; k++) begin
      @(posedge clk); #1;
      a_start = (k == 0);
      @(negedge clk);
      ew = (k >= 1 && k <= 6);
      er = (k >= 2 && k <= 7);
      ed = (k == 8);
      eb = (k >= 1 && k <= 7);
      exp_v = {ew, ew ? iter_vec(k - 1, 3, 2) : ZV, er, er ? iter_vec(k - 2, 3, 2) : ZV, ed, eb};
      obs_v = {a_wen, ew ? a_wvars : ZV, a_ren, er ? a_rvars : ZV, a_done, a_busy};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL full_pass cyc %0d: got %h want %h", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_stall();
    logic ew, er, ed, eb;
    int wi, ri;
    logic [99:0] exp_v, obs_v;
    for (int k = 0; k <= 11; k++) begin
      @(posedge clk); #1;
      a_start = (k == 0);
      a_stall = (k == 3 || k == 4);
      @(negedge clk);
      ew = (k >= 1 && k <= 2) || (k >= 5 && k <= 8);
      wi = (k <= 2) ? k - 1 : k - 3;
      er = (k == 2) || (k >= 5 && k <= 9);
      ri = (k == 2) ? 0 : k - 4;
      ed = (k == 10);
      eb = (k >= 1 && k <= 9);
      exp_v = {ew, ew ? iter_vec(wi, 3, 2) : ZV, er, er ? iter_vec(ri, 3, 2) : ZV, ed, eb};
      obs_v = {a_wen, ew ? a_wvars : ZV, a_ren, er ? a_rvars : ZV, a_done, a_busy};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL stall cyc %0d: got %h want %h", k, obs_v, exp_v);
      end
    end
    a_stall = 1'b0;
  endtask

  task automatic test_flush();
    logic ew, er, ed, eb;
    logic [99:0] exp_v, obs_v;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1;
      a_start = (k == 0 || k == 4 || k == 11);
      a_flush = (k == 4);
      a_stall = (k == 4);
      @(negedge clk);
      ew = (k >= 1 && k <= 3) || (k >= 12 && k <= 17);
      er = (k >= 2 && k <= 3) || (k >= 13 && k <= 18);
      ed = (k == 19);
      eb = (k >= 1 && k <= 4) || (k >= 12 && k <= 18);
      exp_v = {ew, ew ? iter_vec((k >= 12) ? k - 12 : k - 1, 3, 2) : ZV,
               er, er ? iter_vec((k >= 13) ? k - 13 : k - 2, 3, 2) : ZV, ed, eb};
      obs_v = {a_wen, ew ? a_wvars : ZV, a_ren, er ? a_rvars : ZV, a_done, a_busy};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL flush cyc %0d: got %h want %h", k, obs_v, exp_v);
      end
      if (k == 5) begin
        checks++;
        if ({a_wvars, a_rvars} !== '0) begin
          errors++;
          $display("FAIL flush_vars_zero: got %h want 0", {a_wvars, a_rvars});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ew, er, ed, eb;
    logic [99:0] exp_v, obs_v;
    for (int k = 0; k <= 17; k++) begin
      @(posedge clk); #1;
      a_start = (k == 0 || k == 3 || k == 8);
      @(negedge clk);
      ew = (k >= 1 && k <= 6) || (k >= 9 && k <= 14);
      er = (k >= 2 && k <= 7) || (k >= 10 && k <= 15);
      ed = (k == 8 || k == 16);
      eb = (k >= 1 && k <= 7) || (k >= 9 && k <= 15);
      exp_v = {ew, ew ? iter_vec((k >= 9) ? k - 9 : k - 1, 3, 2) : ZV,
               er, er ? iter_vec((k >= 10) ? k - 10 : k - 2, 3, 2) : ZV, ed, eb};
      obs_v = {a_wen, ew ? a_wvars : ZV, a_ren, er ? a_rvars : ZV, a_done, a_busy};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: got %h want %h", k, obs_v, exp_v);
      end
    end
    a_start = 1'b0;
  endtask

  task automatic test_delay0();
    logic ew, ed, eb;
    logic [99:0] exp_v, obs_v;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #1;
      z_start = (k == 0);
      @(negedge clk);
      ew = (k >= 1 && k <= 6);
      ed = (k == 7);
      eb = (k >= 1 && k <= 6);
      exp_v = {ew, ew ? iter_vec(k - 1, 3, 2) : ZV, ew, ew ? iter_vec(k - 1, 3, 2) : ZV, ed, eb};
      obs_v = {z_wen, ew ? z_wvars : ZV, z_ren, ew ? z_rvars : ZV, z_done, z_busy};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL delay0 cyc %0d: got %h want %h", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_outer_carry();
    logic ew, er, ed, eb;
    logic [99:0] exp_v, obs_v;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #1;
      c_start = (k == 0);
      @(negedge clk);
      ew = (k >= 1 && k <= 8);
      er = (k >= 3 && k <= 10);
      ed = (k == 11);
      eb = (k >= 1 && k <= 10);
      exp_v = {ew, ew ? iter_vec(k - 1, 2, 2) : ZV, er, er ? iter_vec(k - 3, 2, 2) : ZV, ed, eb};
      obs_v = {c_wen, ew ? c_wvars : ZV, c_ren, er ? c_rvars : ZV, c_done, c_busy};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL outer_carry cyc %0d: got %h want %h", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_pass();
    logic seen;
    @(posedge clk); #1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_busy, a_wen} !== 2'b11) begin
      errors++;
      $display("FAIL mid_pass_running: got %b want 11", {a_busy, a_wen});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_wen, a_ren, a_busy, a_done, a_wvars, a_rvars} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", {a_wen, a_ren, a_busy, a_done, a_wvars, a_rvars});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | a_done | a_wen | a_ren | a_busy;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL no_done_after_reset: got activity %b want 0", seen);
    end
  endtask

  initial begin
    a_flush = 1'b0; a_start = 1'b0; a_stall = 1'b0;
    z_flush = 1'b0; z_start = 1'b0; z_stall = 1'b0;
    c_flush = 1'b0; c_start = 1'b0; c_stall = 1'b0;
    test_reset();
    test_full_pass();
    test_stall();
    test_flush();
    test_back_to_back();
    test_delay0();
    test_outer_carry();
    test_reset_mid_pass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
